// File: rtl/multimode_register.sv
// Multi-mode WIDTH-bit storage register: hold, load, toggle, JK, shifts and rotates,
// with a complement output held in its own flops and a registered change-detect pulse.
module multimode_register #(
  parameter int unsigned       WIDTH   = 8,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] k,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             changed
);

  typedef enum logic [2:0] {
    MODE_HOLD   = 3'd0,
    MODE_LOAD   = 3'd1,
    MODE_TOGGLE = 3'd2,
    MODE_JK     = 3'd3,
    MODE_SHL    = 3'd4,
    MODE_SHR    = 3'd5,
    MODE_ROL    = 3'd6,
    MODE_ROR    = 3'd7
  } mode_t;

  logic [WIDTH-1:0] shl_val;
  logic [WIDTH-1:0] shr_val;
  logic [WIDTH-1:0] rol_val;
  logic [WIDTH-1:0] ror_val;
  logic [WIDTH-1:0] next_q;

  // A single-bit register has no neighbours: shifts take ser_in and rotates hold.
  generate
    if (WIDTH == 1) begin : g_narrow
      assign shl_val = ser_in;
      assign shr_val = ser_in;
      assign rol_val = q;
      assign ror_val = q;
    end else begin : g_wide
      assign shl_val = {q[WIDTH-2:0], ser_in};
      assign shr_val = {ser_in, q[WIDTH-1:1]};
      assign rol_val = {q[WIDTH-2:0], q[WIDTH-1]};
      assign ror_val = {q[0], q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    next_q = q;
    if (clr) begin
      next_q = RST_VAL;
    end else if (en) begin
      case (mode_t'(mode))
        MODE_HOLD:   next_q = q;
        MODE_LOAD:   next_q = d;
        MODE_TOGGLE: next_q = q ^ d;
        MODE_JK:     next_q = (d & ~q) | (~k & q);
        MODE_SHL:    next_q = shl_val;
        MODE_SHR:    next_q = shr_val;
        MODE_ROL:    next_q = rol_val;
        MODE_ROR:    next_q = ror_val;
        default:     next_q = q;
      endcase
    end
  end

  // qn gets its own flops so it never depends combinationally on q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q       <= RST_VAL;
      qn      <= ~RST_VAL;
      changed <= 1'b0;
    end else begin
      q       <= next_q;
      qn      <= ~next_q;
      changed <= (next_q != q);
    end
  end

endmodule

// File: tb/tb_multimode_register.sv
// Directed self-checking bench for multimode_register: an 8-bit instance with
// RST_VAL=A5 and a 1-bit instance with RST_VAL=0 share clock and reset.
module tb_multimode_register;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr, en, ser_in;
  logic [2:0] mode;
  logic [7:0] d, k;
  logic [7:0] q, qn;
  logic       changed;

  logic       clr1, en1, ser1, d1, k1;
  logic [2:0] mode1;
  logic       q1, qn1, changed1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multimode_register #(.WIDTH(8), .RST_VAL(8'hA5)) dut8 (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .mode(mode), .d(d), .k(k),
    .ser_in(ser_in), .q(q), .qn(qn), .changed(changed)
  );

  multimode_register #(.WIDTH(1), .RST_VAL(1'b0)) dut1 (
    .clk(clk), .rst(rst), .clr(clr1), .en(en1), .mode(mode1), .d(d1), .k(k1),
    .ser_in(ser1), .q(q1), .qn(qn1), .changed(changed1)
  );

  // Inputs change 1 time unit after a rising edge, outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check8(input string name, input logic [7:0] exp_q, input logic exp_ch);
    total++;
    if (q !== exp_q) begin
      bad++;
      $display("[TB] FAIL %s_q got=%h want=%h", name, q, exp_q);
    end
    total++;
    if (qn !== ~exp_q) begin
      bad++;
      $display("[TB] FAIL %s_qn got=%h want=%h", name, qn, ~exp_q);
    end
    total++;
    if (changed !== exp_ch) begin
      bad++;
      $display("[TB] FAIL %s_changed got=%b want=%b", name, changed, exp_ch);
    end
  endtask

  task automatic load8(input logic [7:0] v);
    clr = 0; en = 1; mode = 3'd1; d = v;
    step();
  endtask

  task automatic test_reset();
    load8(8'h3C);
    rst = 1;
    #2;
    check8("rst_async", 8'hA5, 1'b0);
    en = 1; mode = 3'd1; d = 8'hFF;
    step();
    check8("rst_held", 8'hA5, 1'b0);
    rst = 0;
  endtask

  task automatic test_load_hold();
    load8(8'h3C);
    check8("load", 8'h3C, 1'b1);
    load8(8'h3C);
    check8("load_same", 8'h3C, 1'b0);
    en = 0; d = 8'hFF;
    step();
    check8("en_low", 8'h3C, 1'b0);
  endtask

  task automatic test_toggle_jk();
    en = 1; mode = 3'd2; d = 8'h0F;
    step();
    check8("toggle", 8'h33, 1'b1);
    mode = 3'd3; d = 8'hF0; k = 8'h0F;
    step();
    check8("jk_set_clr", 8'hF0, 1'b1);
    d = 8'hFF; k = 8'hFF;
    step();
    check8("jk_toggle", 8'h0F, 1'b1);
    d = 8'h00; k = 8'h00;
    step();
    check8("jk_hold", 8'h0F, 1'b0);
  endtask

  task automatic test_shift_rotate();
    logic [7:0] exp_v;
    load8(8'h81);
    mode = 3'd4; ser_in = 0;
    step();
    check8("shl", 8'h02, 1'b1);
    mode = 3'd5; ser_in = 1;
    step();
    check8("shr", 8'h81, 1'b1);
    mode = 3'd6;
    step();
    check8("rol", 8'h03, 1'b1);
    mode = 3'd7;
    step();
    check8("ror", 8'h81, 1'b1);
    load8(8'h00);
    exp_v = 8'h00;
    mode = 3'd4; ser_in = 1;
    for (int i = 0; i < 8; i++) begin
      step();
      exp_v = {exp_v[6:0], 1'b1};
      check8("shl_fill", exp_v, 1'b1);
    end
    total++;
    if (q !== 8'hFF) begin
      bad++;
      $display("[TB] FAIL shl_fill_final got=%h want=ff", q);
    end
  endtask

  task automatic test_clear_priority();
    load8(8'h12);
    clr = 1; en = 1; mode = 3'd1; d = 8'h77;
    step();
    check8("clr", 8'hA5, 1'b1);
    step();
    check8("clr_again", 8'hA5, 1'b0);
    clr = 0; en = 0;
  endtask

  task automatic test_width1();
    clr1 = 0; en1 = 1; mode1 = 3'd4; ser1 = 1;
    step();
    total++;
    if (q1 !== 1'b1 || qn1 !== 1'b0 || changed1 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL w1_shl got=%b/%b/%b want=1/0/1", q1, qn1, changed1);
    end
    mode1 = 3'd6;
    step();
    total++;
    if (q1 !== 1'b1 || changed1 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL w1_rol got=%b/%b want=1/0", q1, changed1);
    end
    mode1 = 3'd3; d1 = 1; k1 = 1;
    step();
    total++;
    if (q1 !== 1'b0 || qn1 !== 1'b1 || changed1 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL w1_jk got=%b/%b/%b want=0/1/1", q1, qn1, changed1);
    end
    mode1 = 3'd5; ser1 = 1;
    step();
    total++;
    if (q1 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL w1_shr got=%b want=1", q1);
    end
    mode1 = 3'd7;
    step();
    total++;
    if (q1 !== 1'b1 || changed1 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL w1_ror got=%b/%b want=1/0", q1, changed1);
    end
    en1 = 0;
  endtask

  initial begin
    rst = 1; clr = 0; en = 0; mode = 3'd0; d = 8'h00; k = 8'h00; ser_in = 0;
    clr1 = 0; en1 = 0; mode1 = 3'd0; d1 = 0; k1 = 0; ser1 = 0;
    step();
    step();
    rst = 0;
    total++;
    if (q1 !== 1'b0 || qn1 !== 1'b1 || changed1 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL w1_reset got=%b/%b/%b want=0/1/0", q1, qn1, changed1);
    end
    check8("init_reset", 8'hA5, 1'b0);
    test_reset();
    test_load_hold();
    test_toggle_jk();
    test_shift_rotate();
    test_clear_priority();
    test_width1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
